// File: rtl/i2c_led_pkg.sv
// Shared definitions for the I2C-to-WS2812 LED bridge.
//   - i2c_state_t   : I2C slave FSM states
//   - BYTES_PER_LED : colour bytes per LED (G, R, B)
//   - BITS_PER_BYTE : serial bits per byte
package i2c_led_pkg;

    localparam int BYTES_PER_LED = 3;
    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_led_if.sv
// Pad-side bundle of the LED bridge.
//   scl_i/sda_i : I2C pad inputs (asynchronous)
//   scl_o/sda_o : open-drain pull-low enables (1 = drive low)
//   led_o       : WS2812 serial data
//   fsm_state   : debug view of the I2C slave FSM
// slave modport is used by the design, master modport by whatever drives the pads.
interface i2c_led_if;
    import i2c_led_pkg::*;

    logic       scl_i;
    logic       scl_o;
    logic       sda_i;
    logic       sda_o;
    logic       led_o;
    i2c_state_t fsm_state;

    modport slave (
        input  scl_i, sda_i,
        output scl_o, sda_o, led_o, fsm_state
    );

    modport master (
        output scl_i, sda_i,
        input  scl_o, sda_o, led_o, fsm_state
    );

endinterface

// File: rtl/i2c_led_ws2812_tx.sv
// ws2812_tx: free-running WS2812 frame/bit timer.
//   clk, reset : system clock, synchronous active-low reset
//   byte_idx   : buffer byte being (or about to be) transmitted
//   byte_data  : buffer contents at byte_idx
//   led        : serial output (registered)
// Frame = TRST low cycles, then LED_CNT*24 bits of TBIT cycles each, byte 0
// first, MSB first. Each bit value is fetched on the cycle its timer slot starts.
module ws2812_tx
    import i2c_led_pkg::*;
#(
    parameter int LED_CNT = 3,
    parameter int T0H     = 20,
    parameter int T1H     = 40,
    parameter int TBIT    = 63,
    parameter int TRST    = 3000,
    parameter int BW      = $clog2(LED_CNT * BYTES_PER_LED * BITS_PER_BYTE) - 3
) (
    input  logic          clk,
    input  logic          reset,
    output logic [BW-1:0] byte_idx,
    input  logic [7:0]    byte_data,
    output logic          led
);

    localparam int NBITS = LED_CNT * BYTES_PER_LED * BITS_PER_BYTE;
    localparam int IW    = $clog2(NBITS);
    localparam int CMAX  = (TRST > TBIT) ? TRST : TBIT;
    localparam int CW    = $clog2(CMAX);

    logic          in_gap, in_gap_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic          bit_val, bit_val_n;
    logic          led_n;

    // The buffer is addressed with the next bit index so the fetched value
    // lines up with the registered output in the first cycle of the bit.
    assign byte_idx = idx_n[IW-1:3];

    always_comb begin
        in_gap_n  = in_gap;
        cnt_n     = cnt + CW'(1);
        idx_n     = idx;
        bit_val_n = bit_val;
        if (in_gap) begin
            if (cnt == CW'(TRST - 1)) begin
                in_gap_n = 1'b0;
                cnt_n    = '0;
                idx_n    = '0;
            end
        end else if (cnt == CW'(TBIT - 1)) begin
            cnt_n = '0;
            if (idx == IW'(NBITS - 1)) begin
                in_gap_n = 1'b1;
            end else begin
                idx_n = idx + IW'(1);
            end
        end
        if (!in_gap_n && cnt_n == '0) begin
            bit_val_n = byte_data[3'd7 - idx_n[2:0]];
        end
        led_n = !in_gap_n && (cnt_n < (bit_val_n ? CW'(T1H) : CW'(T0H)));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_gap  <= 1'b1;
            cnt     <= '0;
            idx     <= '0;
            bit_val <= 1'b0;
            led     <= 1'b0;
        end else begin
            in_gap  <= in_gap_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            bit_val <= bit_val_n;
            led     <= led_n;
        end
    end

endmodule

// File: rtl/i2c_led.sv
// i2c_led: write-only I2C slave filling a GRB byte buffer that a WS2812
// transmitter streams out continuously.
//   clk, reset : system clock, synchronous active-low reset
//   bus        : pad bundle (scl/sda in + pull-low enables, led_o, fsm_state)
// Byte 3k+0/1/2 = LED k green/red/blue. Each START rewinds the write pointer.
module i2c_led
    import i2c_led_pkg::*;
#(
    parameter logic [6:0] ADDRESS = 7'h4A,
    parameter int         LED_CNT = 3,
    parameter int         T0H     = 20,
    parameter int         T1H     = 40,
    parameter int         TBIT    = 63,
    parameter int         TRST    = 3000
) (
    input  logic        clk,
    input  logic        reset,
    i2c_led_if.slave    bus
);

    localparam int NBYTES = LED_CNT * BYTES_PER_LED;
    localparam int PW     = $clog2(NBYTES + 1);
    localparam int BW     = $clog2(NBYTES * BITS_PER_BYTE) - 3;

    // Synchronisers reset to the idle-bus level so reset cannot fake an edge.
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl, sda, scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_i};
            sda_sync <= {sda_sync[0], bus.sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl       = scl_sync[1];
    assign sda       = sda_sync[1];
    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    assign start_det = scl & scl_d & sda_d & ~sda;
    assign stop_det  = scl & scl_d & ~sda_d & sda;

    i2c_state_t    state, state_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic [PW-1:0] wr_ptr, wr_ptr_n;
    logic          sda_q, sda_n;
    logic          wr_en;
    logic [7:0]    buffer [NBYTES];
    logic [BW-1:0] rd_idx;

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        wr_ptr_n  = wr_ptr;
        sda_n     = sda_q;
        wr_en     = 1'b0;
        if (start_det) begin
            state_n   = ST_ADDR;
            bit_cnt_n = '0;
            wr_ptr_n  = '0;
            sda_n     = 1'b0;
        end else if (stop_det) begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
            sda_n     = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n   = {shift[6:0], sda};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_n = '0;
                        if (state == ST_ADDR) begin
                            if (shift == {ADDRESS, 1'b0}) begin
                                state_n = ST_ADDR_ACK;
                                sda_n   = 1'b1;
                            end else begin
                                state_n = ST_IGNORE;
                            end
                        end else begin
                            // Past the end of the buffer the byte is dropped
                            // and the ACK slot is left released (NACK).
                            state_n = ST_DATA_ACK;
                            if (wr_ptr < PW'(NBYTES)) begin
                                wr_en    = 1'b1;
                                wr_ptr_n = wr_ptr + PW'(1);
                                sda_n    = 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (scl_fall) begin
                        state_n = ST_DATA;
                        sda_n   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            wr_ptr  <= '0;
            sda_q   <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            wr_ptr  <= wr_ptr_n;
            sda_q   <= sda_n;
            if (wr_en) begin
                buffer[wr_ptr[BW-1:0]] <= shift;
            end
        end
    end

    ws2812_tx #(
        .LED_CNT (LED_CNT),
        .T0H     (T0H),
        .T1H     (T1H),
        .TBIT    (TBIT),
        .TRST    (TRST),
        .BW      (BW)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .byte_idx  (rd_idx),
        .byte_data (buffer[rd_idx]),
        .led       (bus.led_o)
    );

    assign bus.scl_o     = 1'b0;
    assign bus.sda_o     = sda_q;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_i2c_led.sv
// Bench for i2c_led: an open-drain I2C master driver, a byte-level model of
// the slave (address match, write pointer, buffer limit) and a WS2812 frame
// decoder that measures pulse widths on led_o.
module tb_i2c_led;
    import i2c_led_pkg::*;

    localparam int T0H     = 20;
    localparam int T1H     = 40;
    localparam int TBIT    = 63;
    localparam int TRST    = 3000;
    localparam int LED_CNT = 3;
    localparam int NBYTES  = 9;
    localparam int HALF    = 6;
    localparam logic [7:0] ADDR_W = 8'h94;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    i2c_led_if bus ();
    assign bus.scl_i = scl_m & ~bus.scl_o;
    assign bus.sda_i = sda_m & ~bus.sda_o;

    i2c_led #(
        .ADDRESS (7'h4A), .LED_CNT (LED_CNT), .T0H (T0H), .T1H (T1H),
        .TBIT (TBIT), .TRST (TRST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // ---------------- reference model / scoreboard ----------------
    logic [7:0] model_buf [NBYTES];
    int         model_ptr;
    logic [1:0] exp_q [$];   // 1 = ACK, 0 = NACK
    logic [1:0] obs_q [$];   // 1 = held low, 0 = released, 2 = changed mid-phase

    task automatic model_clear();
        for (int i = 0; i < NBYTES; i++) model_buf[i] = 8'h00;
        model_ptr = 0;
    endtask

    task automatic model_txn(input logic [7:0] addr_byte, input logic [7:0] data[$]);
        bit ok;
        ok = (addr_byte == ADDR_W);
        model_ptr = 0;
        exp_q.push_back(ok ? 2'd1 : 2'd0);
        foreach (data[k]) begin
            if (ok && model_ptr < NBYTES) begin
                model_buf[model_ptr] = data[k];
                model_ptr++;
                exp_q.push_back(2'd1);
            end else begin
                exp_q.push_back(2'd0);
            end
        end
    endtask

    // ---------------- I2C driver ----------------
    task automatic wait_half();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1; wait_half();
            scl_m = 1'b1; wait_half();
        end
        sda_m = 1'b0; wait_half();
        scl_m = 1'b0; wait_half();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_half();
        scl_m = 1'b1; wait_half();
        sda_m = 1'b1; wait_half();
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_half();
            scl_m = 1'b1; wait_half();
            scl_m = 1'b0;
        end
    endtask

    task automatic ack_slot();
        bit all_low, all_high;
        all_low = 1'b1; all_high = 1'b1;
        sda_m = 1'b1; wait_half();
        scl_m = 1'b1;
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            if (bus.sda_i) all_low = 1'b0; else all_high = 1'b0;
        end
        scl_m = 1'b0;
        obs_q.push_back(all_low ? 2'd1 : (all_high ? 2'd0 : 2'd2));
    endtask

    task automatic i2c_txn(input logic [7:0] addr_byte, input logic [7:0] data[$], input bit end_stop);
        i2c_start();
        send_bits(addr_byte); ack_slot();
        foreach (data[k]) begin
            send_bits(data[k]); ack_slot();
        end
        if (end_stop) i2c_stop();
    endtask

    // ---------------- LED frame decoder ----------------
    logic [7:0] frame_bytes [NBYTES];
    int         frame_bad, frame_gap, frame_first_h;
    bit         frame_to;

    task automatic capture_frame();
        int run, h, l, budget;
        frame_bad = 0; frame_gap = 0; frame_first_h = 0; frame_to = 1'b0;
        for (int i = 0; i < NBYTES; i++) frame_bytes[i] = 8'h00;
        run = 0; budget = 0;
        while (run < 200 && budget < 20000) begin
            @(negedge clk); budget++;
            run = bus.led_o ? 0 : run + 1;
        end
        if (run < 200) begin frame_to = 1'b1; return; end
        budget = 0;
        while (!bus.led_o && budget < TRST + 10) begin @(negedge clk); budget++; end
        if (!bus.led_o) begin frame_to = 1'b1; return; end
        for (int b = 0; b < NBYTES * 8; b++) begin
            h = 0;
            while (bus.led_o && h < 200) begin h++; @(negedge clk); end
            if (b == 0) frame_first_h = h;
            if (h != T0H && h != T1H) frame_bad++;
            frame_bytes[b / 8][7 - (b % 8)] = (h == T1H);
            l = 0;
            if (b < NBYTES * 8 - 1) begin
                while (!bus.led_o && l < 200) begin l++; @(negedge clk); end
                if (h + l != TBIT) frame_bad++;
            end else begin
                while (!bus.led_o && l < TRST + 200) begin l++; @(negedge clk); end
                frame_gap = l - (TBIT - h);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int nz, low;
        reset = 1'b0;
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (4) @(negedge clk);
        check_cnt++; if (bus.sda_o !== 1'b0) $display("FAIL reset_sda_o: got %b expected 0", bus.sda_o); else pass_cnt++;
        check_cnt++; if (bus.scl_o !== 1'b0) $display("FAIL reset_scl_o: got %b expected 0", bus.scl_o); else pass_cnt++;
        check_cnt++; if (bus.led_o !== 1'b0) $display("FAIL reset_led_o: got %b expected 0", bus.led_o); else pass_cnt++;
        check_cnt++; if (bus.fsm_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", bus.fsm_state, ST_IDLE); else pass_cnt++;
        nz = 0;
        for (int i = 0; i < NBYTES; i++) if (dut.buffer[i] !== 8'h00) nz++;
        check_cnt++; if (nz != 0) $display("FAIL reset_buffer: got %0d nonzero bytes expected 0", nz); else pass_cnt++;
        model_clear();
        reset = 1'b1;
        low = 0;
        while (!bus.led_o && low < TRST + 100) begin low++; @(negedge clk); end
        check_cnt++; if (low != TRST) $display("FAIL reset_first_gap: got %0d expected %0d", low, TRST); else pass_cnt++;
    endtask

    task automatic test_idle_frame();
        capture_frame();
        check_cnt++; if (frame_to) $display("FAIL idle_frame_timeout: got 1 expected 0"); else pass_cnt++;
        check_cnt++; if (frame_bad != 0) $display("FAIL idle_pulse_timing: got %0d bad expected 0", frame_bad); else pass_cnt++;
        check_cnt++; if (frame_gap != TRST) $display("FAIL idle_gap: got %0d expected %0d", frame_gap, TRST); else pass_cnt++;
        for (int i = 0; i < NBYTES; i++) begin
            check_cnt++;
            if (frame_bytes[i] !== 8'h00) $display("FAIL idle_byte%0d: got %h expected 00", i, frame_bytes[i]); else pass_cnt++;
        end
    endtask

    task automatic test_write_basic();
        logic [7:0] d[$];
        logic [1:0] e, o;
        d = {8'h71, 8'hA8, 8'hA8};
        model_txn(ADDR_W, d);
        i2c_txn(ADDR_W, d, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'd3;
            check_cnt++; if (o !== e) $display("FAIL basic_ack: got %0d expected %0d", o, e); else pass_cnt++;
        end
        for (int i = 0; i < NBYTES; i++) begin
            check_cnt++;
            if (dut.buffer[i] !== model_buf[i]) $display("FAIL basic_buf%0d: got %h expected %h", i, dut.buffer[i], model_buf[i]); else pass_cnt++;
        end
        capture_frame();
        check_cnt++; if (frame_to) $display("FAIL basic_frame_timeout: got 1 expected 0"); else pass_cnt++;
        check_cnt++; if (frame_bad != 0) $display("FAIL basic_pulse_timing: got %0d bad expected 0", frame_bad); else pass_cnt++;
        check_cnt++; if (frame_first_h != T0H) $display("FAIL basic_first_pulse: got %0d expected %0d", frame_first_h, T0H); else pass_cnt++;
        for (int i = 0; i < NBYTES; i++) begin
            check_cnt++;
            if (frame_bytes[i] !== model_buf[i]) $display("FAIL basic_led_byte%0d: got %h expected %h", i, frame_bytes[i], model_buf[i]); else pass_cnt++;
        end
    endtask

    task automatic test_bad_addr();
        logic [7:0] d[$];
        logic [1:0] e, o;
        d = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        model_txn(8'h96, d); i2c_txn(8'h96, d, 1'b1);
        d = {8'($urandom_range(0, 255))};
        model_txn(8'h95, d); i2c_txn(8'h95, d, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'd3;
            check_cnt++; if (o !== e) $display("FAIL badaddr_ack: got %0d expected %0d", o, e); else pass_cnt++;
        end
        for (int i = 0; i < NBYTES; i++) begin
            check_cnt++;
            if (dut.buffer[i] !== model_buf[i]) $display("FAIL badaddr_buf%0d: got %h expected %h", i, dut.buffer[i], model_buf[i]); else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d[$];
        logic [1:0] e, o;
        for (int i = 0; i < 10; i++) d.push_back(8'($urandom_range(0, 255)));
        model_txn(ADDR_W, d); i2c_txn(ADDR_W, d, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'd3;
            check_cnt++; if (o !== e) $display("FAIL overflow_ack: got %0d expected %0d", o, e); else pass_cnt++;
        end
        for (int i = 0; i < NBYTES; i++) begin
            check_cnt++;
            if (dut.buffer[i] !== model_buf[i]) $display("FAIL overflow_buf%0d: got %h expected %h", i, dut.buffer[i], model_buf[i]); else pass_cnt++;
        end
    endtask

    task automatic test_rep_start();
        logic [7:0] d[$];
        logic [1:0] e, o;
        d = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        model_txn(ADDR_W, d); i2c_txn(ADDR_W, d, 1'b0);
        d = {8'hFF};
        model_txn(ADDR_W, d); i2c_txn(ADDR_W, d, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'd3;
            check_cnt++; if (o !== e) $display("FAIL repstart_ack: got %0d expected %0d", o, e); else pass_cnt++;
        end
        for (int i = 0; i < NBYTES; i++) begin
            check_cnt++;
            if (dut.buffer[i] !== model_buf[i]) $display("FAIL repstart_buf%0d: got %h expected %h", i, dut.buffer[i], model_buf[i]); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [7:0] d[$];
        logic [7:0] a;
        logic [1:0] e, o;
        int n;
        for (int t = 0; t < 5; t++) begin
            case ($urandom_range(0, 4))
                0:       a = 8'h96;
                1:       a = 8'h95;
                default: a = ADDR_W;
            endcase
            d.delete();
            n = $urandom_range(0, 11);
            for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
            model_txn(a, d);
            i2c_txn(a, d, (t == 4) ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'd3;
            check_cnt++; if (o !== e) $display("FAIL random_ack: got %0d expected %0d", o, e); else pass_cnt++;
        end
        capture_frame();
        check_cnt++; if (frame_to) $display("FAIL random_frame_timeout: got 1 expected 0"); else pass_cnt++;
        check_cnt++; if (frame_bad != 0) $display("FAIL random_pulse_timing: got %0d bad expected 0", frame_bad); else pass_cnt++;
        check_cnt++; if (frame_gap != TRST) $display("FAIL random_gap: got %0d expected %0d", frame_gap, TRST); else pass_cnt++;
        for (int i = 0; i < NBYTES; i++) begin
            check_cnt++;
            if (frame_bytes[i] !== model_buf[i]) $display("FAIL random_led_byte%0d: got %h expected %h", i, frame_bytes[i], model_buf[i]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d[$];
        logic [1:0] e, o;
        int budget;
        // Reset while the address ACK is being driven.
        i2c_start();
        send_bits(ADDR_W);
        repeat (5) @(negedge clk);
        check_cnt++; if (bus.sda_o !== 1'b1) $display("FAIL midreset_ack_before: got %b expected 1", bus.sda_o); else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        check_cnt++; if (bus.sda_o !== 1'b0) $display("FAIL midreset_sda_o: got %b expected 0", bus.sda_o); else pass_cnt++;
        check_cnt++; if (bus.fsm_state !== ST_IDLE) $display("FAIL midreset_state: got %0d expected %0d", bus.fsm_state, ST_IDLE); else pass_cnt++;
        reset = 1'b1;
        sda_m = 1'b1; wait_half();
        scl_m = 1'b1; wait_half();
        model_clear();
        // Reset while led_o is high.
        budget = 0;
        while (!bus.led_o && budget < TRST + 200) begin @(negedge clk); budget++; end
        check_cnt++; if (bus.led_o !== 1'b1) $display("FAIL midreset_led_wait: got %b expected 1", bus.led_o); else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        check_cnt++; if (bus.led_o !== 1'b0) $display("FAIL midreset_led_o: got %b expected 0", bus.led_o); else pass_cnt++;
        reset = 1'b1;
        wait_half();
        d = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        model_txn(ADDR_W, d); i2c_txn(ADDR_W, d, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'd3;
            check_cnt++; if (o !== e) $display("FAIL midreset_ack: got %0d expected %0d", o, e); else pass_cnt++;
        end
        for (int i = 0; i < NBYTES; i++) begin
            check_cnt++;
            if (dut.buffer[i] !== model_buf[i]) $display("FAIL midreset_buf%0d: got %h expected %h", i, dut.buffer[i], model_buf[i]); else pass_cnt++;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_idle_frame();
        test_write_basic();
        test_bad_addr();
        test_overflow();
        test_rep_start();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
